// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES-128 round controller.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal,
    StDone
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SelInit  = 2'd0,
    SelRound = 2'd1,
    SelFinal = 2'd2
  } state_sel_e;

  typedef enum logic {
    KeyLoad   = 1'b0,
    KeyExpand = 1'b1
  } key_sel_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: load to 01, double per round, clear between blocks.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  logic       clear,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rcon_q <= 8'h00;
    end else if (load) begin
      rcon_q <= RCON_FIRST;
    end else if (advance) begin
      rcon_q <= xtime(rcon_q);
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 state/key register pair.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       reset,
`ifdef AES_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       state_en,
  output logic [1:0] state_sel,
  output logic       key_en,
  output logic       key_sel,
  output logic [7:0] rcon,
  output logic [3:0] round
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]  round_q, round_d;
  state_sel_e  state_sel_d;
  key_sel_e    key_sel_d;
  logic        rcon_load, rcon_adv, rcon_clr;
  logic [7:0]  rcon_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    state_en    = 1'b0;
    key_en      = 1'b0;
    state_sel_d = SelInit;
    key_sel_d   = KeyLoad;
    rcon_load   = 1'b0;
    rcon_adv    = 1'b0;
    rcon_clr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_en  = 1'b1;
          key_en    = 1'b1;
          state_d   = StRound;
          round_d   = 4'd1;
          rcon_load = 1'b1;
        end
      end
      StRound: begin
        state_en    = 1'b1;
        key_en      = 1'b1;
        state_sel_d = SelRound;
        key_sel_d   = KeyExpand;
        rcon_adv    = 1'b1;
        round_d     = round_q + 4'd1;
        if (round_q == LastRound) state_d = StFinal;
      end
      StFinal: begin
        state_en    = 1'b1;
        key_en      = 1'b1;
        state_sel_d = SelFinal;
        key_sel_d   = KeyExpand;
        rcon_clr    = 1'b1;
        round_d     = 4'd0;
        state_d     = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        round_d = 4'd0;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    if (abort && state_q != StIdle) begin
      out_valid   = 1'b0;
      state_en    = 1'b0;
      key_en      = 1'b0;
      state_sel_d = SelInit;
      key_sel_d   = KeyLoad;
      rcon_adv    = 1'b0;
      rcon_clr    = 1'b1;
      state_d     = StIdle;
      round_d     = 4'd0;
    end
`endif

    // Outputs read idle-quiet for the whole reset cycle, even before state_q settles.
    if (reset) begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      state_en    = 1'b0;
      key_en      = 1'b0;
      state_sel_d = SelInit;
      key_sel_d   = KeyLoad;
    end
  end

  aes_rcon_gen u_rcon_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (rcon_load),
    .advance (rcon_adv),
    .clear   (rcon_clr),
    .rcon    (rcon_q)
  );

  assign state_sel = state_sel_d;
  assign key_sel   = key_sel_d;
  assign rcon      = reset ? 8'h00 : rcon_q;
  assign round     = reset ? 4'd0 : round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a per-cycle phase model and literal pins.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic       state_en, key_en, key_sel, abort;
  logic [1:0] state_sel;
  logic [7:0] rcon;
  logic [3:0] round;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_en  (state_en),
    .state_sel (state_sel),
    .key_en    (key_en),
    .key_sel   (key_sel),
    .rcon      (rcon),
    .round     (round)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ph     = 0;  // 0 idle, 1..9 rounds, 10 final, 11 waiting for consumer
  int acc_q[$];
  logic [7:0] rcon_tbl [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic abort_now();
`ifdef AES_CTRL_ABORT_EN
    return abort;
`else
    return 1'b0;
`endif
  endfunction

  // Phase model advances on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
    if (reset) ph = 0;
    else if (abort_now() && ph != 0) ph = 0;
    else if (ph == 0) begin
      if (in_valid) ph = 1;
    end else if (ph <= 10) ph = ph + 1;
    else if (out_ready) ph = 0;
  end

  always @(negedge clk) begin
    logic       e_ir, e_ov, e_se, e_ke, e_ks;
    logic [1:0] e_ss;
    logic [7:0] e_rc;
    logic [3:0] e_rd;
    e_ir = 0; e_ov = 0; e_se = 0; e_ke = 0; e_ks = 0; e_ss = 0; e_rc = 0; e_rd = 0;
    if (!reset) begin
      if (ph == 0) begin
        e_ir = 1;
        if (in_valid) begin e_se = 1; e_ke = 1; end
      end else if (ph <= 10) begin
        e_rd = 4'(ph);
        e_rc = rcon_tbl[ph];
        if (!abort_now()) begin
          e_se = 1; e_ke = 1; e_ks = 1;
          e_ss = (ph == 10) ? 2'd2 : 2'd1;
        end
      end else begin
        e_ov = !abort_now();
      end
    end
    chk("m_in_ready",  in_ready,  e_ir);
    chk("m_out_valid", out_valid, e_ov);
    chk("m_state_en",  state_en,  e_se);
    chk("m_state_sel", state_sel, e_ss);
    chk("m_key_en",    key_en,    e_ke);
    chk("m_key_sel",   key_sel,   e_ks);
    chk("m_rcon",      rcon,      e_rc);
    chk("m_round",     round,     e_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until out_valid is seen at a falling edge; returns that cycle or -1.
  task automatic wait_ov(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin at = cyc; break; end
      tick();
    end
  endtask

  task automatic wait_round(input logic [3:0] r, output logic found);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (round == r) begin found = 1; break; end
      tick();
    end
  endtask

  initial begin
    logic [7:0] exp_rcon [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0] rq[$];
    int   en_cnt, first_ov, at;
    logic found, ov_seen;

    reset = 1; in_valid = 1; out_ready = 1; abort = 0;
    tick(); tick();
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_state_en", state_en, 0);
    chk("reset_round", round, 0);
    tick();
    reset = 0; in_valid = 0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);

    // Single block, consumer always ready.
    tick();
    acc_q.delete();
    in_valid = 1; en_cnt = 0; first_ov = -1;
    for (int i = 0; i < 40 && first_ov < 0; i++) begin
      @(negedge clk);
      if (state_en) en_cnt++;
      if (state_en && state_sel != 2'd0) rq.push_back(rcon);
      if (out_valid) first_ov = cyc;
      tick();
      in_valid = 0;
    end
    chk("blk_done_seen", first_ov >= 0, 1);
    chk("blk_state_en_cycles", en_cnt, 11);
    chk("blk_rcon_count", rq.size(), 10);
    for (int k = 0; k < 10 && k < rq.size(); k++) chk("blk_rcon_seq", rq[k], exp_rcon[k]);
    chk("blk_accept_count", acc_q.size(), 1);
    // DONE is visible right after the tenth edge following the accepting edge.
    if (acc_q.size() > 0) chk("blk_latency", first_ov - acc_q[0], 10);

    // Consumer stalls for five DONE cycles.
    out_ready = 0; in_valid = 1;
    tick();
    in_valid = 0;
    wait_ov(at);
    chk("stall_done_seen", at >= 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); @(negedge clk); end
      chk("stall_out_valid", out_valid, 1);
      chk("stall_state_en", state_en, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1;
    @(negedge clk);
    chk("stall_6th_out_valid", out_valid, 1);
    tick();
    @(negedge clk);
    chk("stall_released_out_valid", out_valid, 0);
    chk("stall_released_in_ready", in_ready, 1);

    // Back-to-back blocks with in_valid held.
    tick();
    acc_q.delete();
    in_valid = 1;
    for (int i = 0; i < 40 && acc_q.size() < 2; i++) tick();
    in_valid = 0;
    chk("b2b_accept_count", acc_q.size(), 2);
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 12);
    wait_ov(at);
    chk("b2b_second_done", at >= 0, 1);
    tick();

    // Reset in the middle of round 5.
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_round(4'd4, found);
    chk("rst_round4_seen", found, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_idle_round", round, 0);
    chk("rst_idle_in_ready", in_ready, 1);
    ov_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    chk("rst_no_out_valid", ov_seen, 0);
    tick();
    acc_q.delete();
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_ov(at);
    chk("rst_next_done_seen", at >= 0, 1);
    if (acc_q.size() > 0) chk("rst_next_latency", at - acc_q[0], 10);
    tick();

`ifdef AES_CTRL_ABORT_EN
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_round(4'd2, found);
    chk("abort_round2_seen", found, 1);
    tick();
    abort = 1;
    @(negedge clk);
    chk("abort_round", round, 3);
    chk("abort_state_en", state_en, 0);
    chk("abort_key_en", key_en, 0);
    tick();
    abort = 0;
    @(negedge clk);
    chk("abort_idle_round", round, 0);
    chk("abort_idle_in_ready", in_ready, 1);
    tick();
    abort = 1; in_valid = 1;
    @(negedge clk);
    chk("abort_idle_state_en", state_en, 1);
    tick();
    abort = 0; in_valid = 0;
    @(negedge clk);
    chk("abort_idle_accepted_round", round, 1);
    wait_ov(at);
    chk("abort_after_done_seen", at >= 0, 1);
    tick();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
